alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational alu instance between N_REQ requesters, e.g. the
//  integer pipe and the address/branch unit. Arbitration is round-robin and
//  every interface uses valid/ready. Each accepted operation returns one
//  registered result, tagged with the requester index.
//  Sits between issue logic and the shared alu, and owns the alu op/lhs/rhs
//  inputs exclusively.
// PARAMETERS
//  N_REQ    2   number of requesters (2..8)
//  ID_W     1   requester-index width, = $clog2(N_REQ), minimum 1
//  STALL_W  16  width of the saturating stall counter
// PORTS
//  clk        in   1                   clock; all state on rising edge
//  reset      in   1                   synchronous, active-high reset
//  req_valid  in   N_REQ               per-requester operation valid
//  req_ready  out  N_REQ               per-requester accept (one-hot or zero)
//  req_op     in   N_REQ*(ALU_OP_END+1) packed alu ops, requester i at slice i
//  req_lhs    in   N_REQ*32            packed left operands
//  req_rhs    in   N_REQ*32            packed right operands
//  rsp_valid  out  1                   result register holds a valid result
//  rsp_ready  in   1                   downstream consumes result this cycle
//  rsp_id     out  ID_W                index of the requester owning rsp_res
//  rsp_res    out  32                  registered alu result
//  stall_cnt  out  STALL_W             cycles any req_valid=1 but none accepted
// BEHAVIOUR
//  Reset
//   - rsp_valid=0, rsp_id=0, rsp_res=0, stall_cnt=0, rr pointer=0.
//   - req_ready=0 while reset is high.
//   - In-flight result and pending grant are discarded; no response is issued.
//  Slot availability
//   - slot_free = !rsp_valid || rsp_ready.
//   - This gives full throughput: one operation per cycle with back-to-back
//     consume.
//  Grant
//   - When slot_free, scan req_valid starting at index ptr, wrapping
//     N_REQ-1 -> 0. The first valid index g wins.
//   - req_ready[g]=1; all other req_ready bits are 0.
//   - When !slot_free, all req_ready=0.
//   - req_ready depends combinationally on req_valid and rsp_ready; there is
//     no dependency on req_op/lhs/rhs.
//  Accept
//   - An accept is req_valid[g] && req_ready[g] at a rising edge.
//   - On accept: rsp_res <= alu(req_op[g], req_lhs[g], req_rhs[g]);
//     rsp_id <= g; rsp_valid <= 1; ptr <= (g+1) mod N_REQ.
//   - Latency is exactly 1 cycle: accept at edge k, result visible after edge k.
//  Idle and hold
//   - Consume without new accept: rsp_valid <= 0; rsp_res and rsp_id hold.
//   - No accept and no consume: all state holds; rsp_res remains stable while
//     rsp_valid=1 && !rsp_ready.
//   - ptr changes only on accept.
//  Alu inputs
//   - Alu op/lhs/rhs are taken from the granted slice.
//   - With no grant, drive op = the alu's LHS-passthrough op and lhs=rhs=0 to
//     avoid toggling.
//  Fairness
//   - With all N_REQ requesters continuously valid and rsp_ready=1, each
//     requester is granted exactly once per N_REQ cycles.
//   - No requester waits more than N_REQ accepts.
//  Stall counter
//   - stall_cnt increments by 1 in each cycle with |req_valid && !slot_free.
//   - It saturates at all-ones and never wraps. Cleared only by reset.
//  Arithmetic rules
//   - Result semantics and width belong to the alu; this block adds no
//     arithmetic.
//   - An unsupported op yields 0 and is still accepted and returned.
//  Requester obligations
//   - A requester holding req_valid=1 without ready must keep its
//     op/lhs/rhs stable.
//   - This block does not check that rule; a dropped valid simply loses
//     arbitration.
// TESTING
//  1. Single request: req0 ADD 5+7, rsp_ready=1 -> req_ready[0]=1 that
//     cycle; next cycle rsp_valid=1, rsp_id=0, rsp_res=12.
//  2. Contention: N_REQ=2, both valid every cycle (req0 SUB 10-3, req1 SLL
//     1<<4), rsp_ready=1 -> grants alternate 0,1,0,1; results 7,16,7,16;
//     stall_cnt=0.
//  3. Backpressure: rsp_ready=0 with a result held -> req_ready=0, rsp_res
//     stable, stall_cnt +1 per cycle; raise rsp_ready -> same-cycle accept of
//     the next request.
//  4. Saturation: STALL_W=4, hold backpressure for 20 cycles with req valid
//     -> stall_cnt stops at 15.
//  5. Reset mid-operation: accept SRA 0x80000000>>>4, assert reset on the
//     next edge -> rsp_valid=0, rsp_res=0, ptr=0; after release req1-only
//     valid -> granted, rsp_id=1.
//  6. Wrap: N_REQ=3, only req2 and req0 valid, ptr=2 -> order 2,0,2,0;
//     req1 joins -> order continues 0,1,2 with none skipped.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between N_REQ
// valid/ready requesters; each accepted op yields one registered, id-tagged
// result.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req_valid/ready per-requester handshake (ready is one-hot or zero)
//   req_op/lhs/rhs  packed per-requester operation, slice i = requester i
//   rsp_valid/ready result handshake
//   rsp_id, rsp_res owning requester index and registered ALU result
//   stall_cnt       saturating count of cycles with requests but no free slot
// ALU opcodes (op field is ALU_OP_END+1 bits wide):
//   0 PASS(lhs) 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 SLL 7 SRL 8 SRA 9 SLT 10 SLTU,
//   anything else returns 0.

// Combinational ALU shared by all requesters.
module alu_core #(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     lhs,
  input  logic [31:0]     rhs,
  output logic [31:0]     res
);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(10);

  always_comb begin
    res = '0;
    case (op)
      OP_PASS: res = lhs;
      OP_ADD:  res = lhs + rhs;
      OP_SUB:  res = lhs - rhs;
      OP_AND:  res = lhs & rhs;
      OP_OR:   res = lhs | rhs;
      OP_XOR:  res = lhs ^ rhs;
      OP_SLL:  res = lhs << rhs[4:0];
      OP_SRL:  res = lhs >> rhs[4:0];
      OP_SRA:  res = 32'($signed(lhs) >>> rhs[4:0]);
      OP_SLT:  res = {31'b0, ($signed(lhs) < $signed(rhs))};
      OP_SLTU: res = {31'b0, (lhs < rhs)};
      default: res = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ID_W       = 1,
  parameter int unsigned STALL_W    = 16,
  parameter int unsigned ALU_OP_END = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*(ALU_OP_END+1)-1:0] req_op,
  input  logic [N_REQ*32-1:0]             req_lhs,
  input  logic [N_REQ*32-1:0]             req_rhs,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [31:0]                     rsp_res,
  output logic [STALL_W-1:0]              stall_cnt
);
  localparam int unsigned      OP_W    = ALU_OP_END + 1;
  localparam logic [OP_W-1:0]  OP_PASS = OP_W'(0);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] idx;
  logic            gnt_any;
  logic            slot_free;
  logic [OP_W-1:0] alu_op;
  logic [31:0]     alu_lhs;
  logic [31:0]     alu_rhs;
  logic [31:0]     alu_res;

  assign slot_free = !rsp_valid || rsp_ready;

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (slot_free && !reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        idx = ID_W'((32'(ptr) + i) % N_REQ);
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  assign req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;

  // Idle ALU sees a quiet passthrough of zero to avoid toggling.
  always_comb begin
    alu_op  = OP_PASS;
    alu_lhs = '0;
    alu_rhs = '0;
    if (gnt_any) begin
      alu_op  = req_op[gnt_id*OP_W +: OP_W];
      alu_lhs = req_lhs[gnt_id*32 +: 32];
      alu_rhs = req_rhs[gnt_id*32 +: 32];
    end
  end

  alu_core #(.OP_W(OP_W)) u_alu (
    .op  (alu_op),
    .lhs (alu_lhs),
    .rhs (alu_rhs),
    .res (alu_res)
  );

  // Result register, pointer and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      ptr       <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_any) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_res   <= alu_res;
        ptr       <= ID_W'((32'(gnt_id) + 32'd1) % N_REQ);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (|req_valid && !slot_free && stall_cnt != {STALL_W{1'b1}})
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
endmodule
